// File: rtl/uart_reg_arbiter.sv
// uart_reg_arbiter: shares the UART register file between the UART command path (port 0)
// and the host bus (port 1). One access at a time; a write takes IDLE->ACCESS->DONE and a read
// takes IDLE->ACCESS->CAPTURE->DONE. Every output is driven straight from a flop.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req_k/i_we_k           request (held until ack) and write-enable, k = 0, 1
//   i_addr_k/i_wdata_k       register address and write data
//   o_ack_k/o_rdata_k        one-cycle completion pulse, read data valid with the ack
//   o_rd_req/o_wr_req        one-cycle register-file strobes
//   o_rwaddr/o_write_reg     address and write data of the current (or last) access
//   i_read_reg               register-file read data, valid the cycle after o_rd_req
//   o_fifo_fetch             pulse with the ack of a read of UART_DOUTH_OFFSET
//   o_busy                   high whenever the FSM is not idle
//
// Build option: define UART_ARB_ROUND_ROBIN_EN for round-robin tie breaking. Without it,
// port 0 always wins a tie.

package uart_pkg;
  typedef logic [2:0] reg_rwaddr;
  localparam reg_rwaddr UART_DOUTH_OFFSET = 3'd4;
endpackage

module uart_reg_arbiter
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_0,
  input  logic       i_we_0,
  input  reg_rwaddr  i_addr_0,
  input  logic [7:0] i_wdata_0,
  output logic       o_ack_0,
  output logic [7:0] o_rdata_0,
  input  logic       i_req_1,
  input  logic       i_we_1,
  input  reg_rwaddr  i_addr_1,
  input  logic [7:0] i_wdata_1,
  output logic       o_ack_1,
  output logic [7:0] o_rdata_1,
  output logic       o_rd_req,
  output logic       o_wr_req,
  output reg_rwaddr  o_rwaddr,
  output logic [7:0] o_write_reg,
  input  logic [7:0] i_read_reg,
  output logic       o_fifo_fetch,
  output logic       o_busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture, StDone} state_e;

  state_e     state_q, state_d;
  logic       win_q, win_d;      // 1 = port 1 owns the current access
  logic       we_q, we_d;
  reg_rwaddr  addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rd_req_q, rd_req_d;
  logic       wr_req_q, wr_req_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       fetch_q, fetch_d;
  logic       busy_q, busy_d;
  logic       grant1;

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;        // port granted most recently; resets to 1 so port 0 wins first

  always_comb begin
    grant1 = i_req_1;
    if (i_req_0 && i_req_1) grant1 = !last_q;
  end
`else
  always_comb begin
    grant1 = !i_req_0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_req_d = 1'b0;
    wr_req_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    fetch_d  = 1'b0;
`ifdef UART_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_req_0 || i_req_1) begin
          win_d    = grant1;
          we_d     = grant1 ? i_we_1    : i_we_0;
          addr_d   = grant1 ? i_addr_1  : i_addr_0;
          wdata_d  = grant1 ? i_wdata_1 : i_wdata_0;
          // Strobes are registered, so they are set on the edge entering ACCESS.
          rd_req_d = !we_d;
          wr_req_d = we_d;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          ack0_d  = !win_q;
          ack1_d  = win_q;
          state_d = StDone;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (win_q) rdata1_d = i_read_reg;
        else       rdata0_d = i_read_reg;
        ack0_d  = !win_q;
        ack1_d  = win_q;
        fetch_d = (addr_q == UART_DOUTH_OFFSET);
        state_d = StDone;
      end
      StDone: begin
`ifdef UART_ARB_ROUND_ROBIN_EN
        last_d  = win_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      fetch_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      fetch_q  <= fetch_d;
      busy_q   <= busy_d;
`ifdef UART_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign o_ack_0      = ack0_q;
  assign o_ack_1      = ack1_q;
  assign o_rdata_0    = rdata0_q;
  assign o_rdata_1    = rdata1_q;
  assign o_rd_req     = rd_req_q;
  assign o_wr_req     = wr_req_q;
  assign o_rwaddr     = addr_q;
  assign o_write_reg  = wdata_q;
  assign o_fifo_fetch = fetch_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Self-checking bench for uart_reg_arbiter: a table of single accesses plus hand-written
// sequences for reset, ties, a pending loser and reset during a read.
module tb_uart_reg_arbiter;

  localparam logic [2:0] DouthAddr = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [2:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, rd_req, wr_req, fifo_fetch, busy;
  logic [7:0] rdata0, rdata1, write_reg, read_reg;
  logic [2:0] rwaddr;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;

  uart_reg_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_0(req0), .i_we_0(we0), .i_addr_0(addr0), .i_wdata_0(wdata0),
    .o_ack_0(ack0), .o_rdata_0(rdata0),
    .i_req_1(req1), .i_we_1(we1), .i_addr_1(addr1), .i_wdata_1(wdata1),
    .o_ack_1(ack1), .o_rdata_1(rdata1),
    .o_rd_req(rd_req), .o_wr_req(wr_req), .o_rwaddr(rwaddr), .o_write_reg(write_reg),
    .i_read_reg(read_reg), .o_fifo_fetch(fifo_fetch), .o_busy(busy)
  );

  // Register-file model: writes on the strobe, read data valid the cycle after o_rd_req.
  logic [7:0] mem [8];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      read_reg <= 8'h00;
    end else begin
      if (wr_req) mem[rwaddr] <= write_reg;
      if (rd_req) read_reg <= mem[rwaddr];
    end
  end

  typedef struct {
    logic       port;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_ff;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] all_outs();
    return {ack0, ack1, rd_req, wr_req, fifo_fetch, busy, rdata0, rdata1, rwaddr, write_reg};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic [2:0] addr,
                       input logic [7:0] wdata);
    if (port) begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic do_access(input vec_t v);
    logic [7:0] own, other;
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    check("strobe_wr", wr_req, v.we);
    check("strobe_rd", rd_req, !v.we);
    check("strobe_addr", rwaddr, v.addr);
    check("strobe_busy", busy, 1'b1);
    if (v.we) check("strobe_wdata", write_reg, v.wdata);
    if (!v.we) begin
      @(negedge clk);
      check("capture_noack", {ack0, ack1}, 2'b00);
      check("capture_nostrobe", {rd_req, wr_req}, 2'b00);
    end
    @(negedge clk);
    check("ack_winner", v.port ? ack1 : ack0, 1'b1);
    check("ack_loser", v.port ? ack0 : ack1, 1'b0);
    check("fifo_fetch", fifo_fetch, v.exp_ff);
    if (!v.we) last_rd[v.port] = v.exp_rdata;
    own   = v.port ? rdata1 : rdata0;
    other = v.port ? rdata0 : rdata1;
    check("rdata_own", own, last_rd[v.port]);
    check("rdata_other", other, last_rd[!v.port]);
    drive(v.port, 1'b0, v.we, v.addr, v.wdata);
    @(negedge clk);
    check("idle_after", {busy, ack0, ack1, fifo_fetch}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got [$];
    logic exp_port;

    vecs[0] = '{1'b1, 1'b1, 3'd2, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 3'd1, 8'h3C, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'd4, 8'h5A, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 3'd1, 8'h00, 8'h3C, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'd4, 8'h00, 8'h5A, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 3'd2, 8'h00, 8'hA5, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 3'd2, 8'h77, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 3'd2, 8'h00, 8'h77, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'h00, 1'b0};

    // Reset values held over idle cycles.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 33'd0);
    end

    // Single accesses from the table.
    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // Tie: both ports keep writing; record the ack order of six accesses.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'd3, 8'h10);
    drive(1'b1, 1'b1, 1'b1, 3'd6, 8'h20);
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check("tie_one_ack", ack0 & ack1, 1'b0);
        got.push_back(int'(ack1));
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("tie_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) begin
`ifdef UART_ARB_ROUND_ROBIN_EN
      exp_port = (i % 2) == 1;
`else
      exp_port = 1'b0;
`endif
      check($sformatf("tie_grant_%0d", i), got[i], exp_port);
    end
    repeat (3) @(negedge clk);

    // Pending loser: port 1 requests while port 0 is in ACCESS.
    drive(1'b0, 1'b1, 1'b1, 3'd0, 8'h11);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 3'd5, 8'h22);
    check("pend_strobe0_addr", {wr_req, rwaddr, write_reg}, {1'b1, 3'd0, 8'h11});
    @(negedge clk);
    check("pend_ack0", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    @(negedge clk);
    check("pend_idle", {busy, wr_req, ack0, ack1}, 4'b0000);
    @(negedge clk);
    check("pend_strobe1", {wr_req, rwaddr, write_reg}, {1'b1, 3'd5, 8'h22});
    @(negedge clk);
    check("pend_ack1", {ack0, ack1}, 2'b01);
    req1 = 1'b0;
    @(negedge clk);
    check("pend_mem", {mem[0], mem[5]}, 16'h1122);

    // Reset in CAPTURE aborts the read with no ack.
    drive(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
    @(negedge clk);
    check("rstmid_strobe", rd_req, 1'b1);
    @(negedge clk);
    check("rstmid_capture", {busy, ack0, ack1}, 3'b100);
    rst_n = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    check("rstmid_outputs", all_outs(), 33'd0);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid_quiet", {ack0, ack1, busy, rd_req}, 4'b0000);
    end
    do_access('{1'b1, 1'b1, 3'd2, 8'h9C, 8'h00, 1'b0});
    do_access('{1'b0, 1'b0, 3'd2, 8'h00, 8'h9C, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
